// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory bus unit.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Access size codes, shared by the request port and the bus SIZE lines.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int DEFAULT_TIMEOUT = 256;

  // Halfwords need an even address, words a 4-byte-aligned one; any size
  // code that is neither half nor byte is checked as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_BYTE)
      return 1'b0;
    else if (size == SZ_HALF)
      return addr_lo[0];
    else
      return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_bus_if_if.sv
// Request/response handshake plus external data-bus signals of the unit.
interface dmem_bus_if_if #(
  parameter int BIT_WIDTH = 32
);
  // MEM-stage request
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [BIT_WIDTH-1:0] req_addr;
  logic [BIT_WIDTH-1:0] req_wdata;
  logic [4:0]           req_rd;
  // completion
  logic                 resp_valid;
  logic [BIT_WIDTH-1:0] resp_rdata;
  logic [4:0]           resp_rd;
  logic                 resp_err;
  logic                 stall;
  // external data bus
  logic [BIT_WIDTH-1:0] DAD;
  logic                 MREQ;
  logic                 WRITE;
  logic [1:0]           SIZE;
  logic [BIT_WIDTH-1:0] DDT_o;
  logic                 DDT_oe;
  logic [BIT_WIDTH-1:0] DDT_i;
  logic                 ACKD_n;

  // pipeline + memory side
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
    output DDT_i, ACKD_n,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err, stall,
    input  DAD, MREQ, WRITE, SIZE, DDT_o, DDT_oe
  );

  // bus interface unit side
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
    input  DDT_i, ACKD_n,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err, stall,
    output DAD, MREQ, WRITE, SIZE, DDT_o, DDT_oe
  );
endinterface

// File: rtl/dmem_load_ext.sv
// Size/sign extension of right-justified load data.
import dmem_bus_pkg::*;

module dmem_load_ext #(
  parameter int BIT_WIDTH = 32
) (
  input  logic [1:0]           size,
  input  logic                 sign,
  input  logic [BIT_WIDTH-1:0] raw,
  output logic [BIT_WIDTH-1:0] ext
);

  // Replicate the top bit of the accessed lane when signed, else zero-fill.
  always_comb begin
    ext = raw;
    if (size == SZ_BYTE)
      ext = {{(BIT_WIDTH-8){sign & raw[7]}}, raw[7:0]};
    else if (size == SZ_HALF)
      ext = {{(BIT_WIDTH-16){sign & raw[15]}}, raw[15:0]};
  end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface unit: one outstanding access, IDLE -> BUS -> DONE.
import dmem_bus_pkg::*;

module dmem_bus_if #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  dmem_bus_if_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [BIT_WIDTH-1:0] addr_reg, wdata_reg, rdata_reg;
  logic [1:0]           size_reg;
  logic                 write_reg, signed_reg, err_reg;
  logic [4:0]           rd_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BIT_WIDTH-1:0] wdata_fmt;
  logic [BIT_WIDTH-1:0] ext_data;
  logic                 misaligned;
  logic                 timeout_hit;

  assign misaligned  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign timeout_hit = (cnt_reg == CNT_LAST);

  // Store data is right-justified to the access size at accept time.
  always_comb begin
    wdata_fmt = bus.req_wdata;
    if (bus.req_size == SZ_BYTE)
      wdata_fmt = {{(BIT_WIDTH-8){1'b0}}, bus.req_wdata[7:0]};
    else if (bus.req_size == SZ_HALF)
      wdata_fmt = {{(BIT_WIDTH-16){1'b0}}, bus.req_wdata[15:0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state; an ack on the last wait cycle wins over the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.req_valid) state_next = misaligned ? ST_DONE : ST_BUS;
      ST_BUS:  if (!bus.ACKD_n || timeout_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      size_reg   <= SZ_WORD;
      write_reg  <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      rd_reg     <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.req_valid) begin
          addr_reg   <= bus.req_addr;
          wdata_reg  <= wdata_fmt;
          size_reg   <= bus.req_size;
          write_reg  <= bus.req_write;
          signed_reg <= bus.req_signed;
          rd_reg     <= bus.req_rd;
          err_reg    <= misaligned;
          rdata_reg  <= '0;
          cnt_reg    <= '0;
        end
        ST_BUS: begin
          if (!bus.ACKD_n) begin
            rdata_reg <= write_reg ? '0 : bus.DDT_i;
          end else if (timeout_hit) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  dmem_load_ext #(.BIT_WIDTH(BIT_WIDTH)) u_load_ext (
    .size (size_reg),
    .sign (signed_reg),
    .raw  (rdata_reg),
    .ext  (ext_data)
  );

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.stall      = (bus.req_valid & ~bus.req_ready) | (state_reg != ST_IDLE);
  assign bus.resp_valid = (state_reg == ST_DONE);
  assign bus.resp_err   = (state_reg == ST_DONE) & err_reg;
  assign bus.resp_rdata = ext_data;
  assign bus.resp_rd    = rd_reg;
  assign bus.MREQ       = (state_reg == ST_BUS);
  assign bus.DAD        = addr_reg;
  assign bus.WRITE      = write_reg;
  assign bus.SIZE       = size_reg;
  assign bus.DDT_o      = wdata_reg;
  assign bus.DDT_oe     = (state_reg == ST_BUS) & write_reg;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed vector bench for dmem_bus_if (TIMEOUT shortened to 4).
module tb_dmem_bus_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_bus_if_if #(.BIT_WIDTH(32)) bus ();

  dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] ddt_i;
    int          delay;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ddt_o;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = s;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
  endtask

  // Run one vector: accept, optional wait cycles, ack, one-cycle response.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive_req(v.write, v.size, v.sgn, v.addr, v.wdata, v.rd);
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (v.exp_err) begin
      chk("mis_mreq", 32'(bus.MREQ), 32'd0);
      chk("mis_valid", 32'(bus.resp_valid), 32'd1);
      chk("mis_err", 32'(bus.resp_err), 32'd1);
      chk("mis_rdata", bus.resp_rdata, 32'd0);
      chk("mis_rd", 32'(bus.resp_rd), 32'(v.rd));
    end else begin
      chk("bus_mreq", 32'(bus.MREQ), 32'd1);
      chk("bus_dad", bus.DAD, v.addr);
      chk("bus_size", 32'(bus.SIZE), 32'(v.size));
      chk("bus_write", 32'(bus.WRITE), 32'(v.write));
      chk("bus_oe", 32'(bus.DDT_oe), 32'(v.write));
      if (v.write) chk("bus_ddt_o", bus.DDT_o, v.exp_ddt_o);
      chk("bus_stall", 32'(bus.stall), 32'd1);
      chk("bus_ready", 32'(bus.req_ready), 32'd0);
      for (int d = 0; d < v.delay; d++) begin
        @(negedge clk);
        chk("wait_mreq", 32'(bus.MREQ), 32'd1);
        chk("wait_novalid", 32'(bus.resp_valid), 32'd0);
      end
      bus.ACKD_n = 1'b0;
      bus.DDT_i  = v.ddt_i;
      @(negedge clk);
      bus.ACKD_n = 1'b1;
      bus.DDT_i  = 32'hA5A5_A5A5;
      chk("resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("resp_err", 32'(bus.resp_err), 32'd0);
      chk("resp_rdata", bus.resp_rdata, v.exp_rdata);
      chk("resp_rd", 32'(bus.resp_rd), 32'(v.rd));
      chk("done_mreq", 32'(bus.MREQ), 32'd0);
      chk("done_oe", 32'(bus.DDT_oe), 32'd0);
    end
    @(negedge clk);
    chk("pulse_end", 32'(bus.resp_valid), 32'd0);
    chk("back_idle", 32'(bus.req_ready), 32'd1);
    $display("txn %0d: w=%0d size=%0d addr=%h rdata=%h err=%0d", idx, v.write, v.size,
             v.addr, v.exp_rdata, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            w     size   sgn   addr          wdata         rd  ddt_i         dly err   rdata         ddt_o
    vecs[0]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0,        5'd5,  32'h0000_0080, 0, 1'b0, 32'hFFFF_FF80, 32'h0};
    vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        5'd6,  32'h0000_F00D, 0, 1'b0, 32'h0000_F00D, 32'h0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641, 5'd7, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,         32'h0000_0041};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0,        5'd8,  32'h0,        0, 1'b1, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0204, 32'h0,        5'd9,  32'h0000_8001, 2, 1'b0, 32'hFFFF_8001, 32'h0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h0,        5'd10, 32'h0000_00FF, 0, 1'b0, 32'h0000_00FF, 32'h0};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0008, 32'hCAFE_BABE, 5'd11, 32'h0,       1, 1'b0, 32'h0,         32'hCAFE_BABE};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h1111_2222, 5'd12, 32'h0,       0, 1'b1, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_000C, 32'h0,        5'd13, 32'h8000_0000, 0, 1'b0, 32'h8000_0000, 32'h0};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'hAAAA_5555, 5'd14, 32'h0,       0, 1'b0, 32'h0,         32'h0000_5555};
    vecs[10] = '{1'b0, 2'b10, 1'b1, 32'h0000_0011, 32'h0,        5'd15, 32'h0000_007F, 0, 1'b0, 32'h0000_007F, 32'h0};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    bus.DDT_i = '0; bus.ACKD_n = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mreq", 32'(bus.MREQ), 32'd0);
    chk("rst_write", 32'(bus.WRITE), 32'd0);
    chk("rst_oe", 32'(bus.DDT_oe), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_dad", bus.DAD, 32'd0);
    chk("rst_ddt_o", bus.DDT_o, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_size", 32'(bus.SIZE), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    $display("txn reset: outputs checked");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Timeout: ACKD_n low while idle is ignored, then held high through BUS.
    @(negedge clk);
    bus.ACKD_n = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", 32'(bus.resp_valid), 32'd0);
    drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 5'd20);
    bus.ACKD_n = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to_mreq", 32'(bus.MREQ), 32'd1);
      chk("to_novalid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("to_mreq_off", 32'(bus.MREQ), 32'd0);
    chk("to_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_err", 32'(bus.resp_err), 32'd1);
    chk("to_rdata", bus.resp_rdata, 32'd0);
    chk("to_rd", 32'(bus.resp_rd), 32'd20);
    @(negedge clk);
    chk("to_pulse_end", 32'(bus.resp_valid), 32'd0);
    $display("txn timeout: err response after 4 MREQ cycles");

    // Reset in the second BUS cycle aborts the access.
    drive_req(1'b1, 2'b00, 1'b0, 32'h0000_0080, 32'h5555_AAAA, 5'd21);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("ab_mreq1", 32'(bus.MREQ), 32'd1);
    @(negedge clk);
    chk("ab_mreq2", 32'(bus.MREQ), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_mreq_off", 32'(bus.MREQ), 32'd0);
    chk("ab_novalid", 32'(bus.resp_valid), 32'd0);
    chk("ab_oe", 32'(bus.DDT_oe), 32'd0);
    chk("ab_dad", bus.DAD, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ab_still_novalid", 32'(bus.resp_valid), 32'd0);
    end
    $display("txn abort: reset during BUS");

    // No accept in the DONE cycle: misaligned request, valid held high.
    drive_req(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0, 5'd22);
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b1, 32'h0000_0030, 32'h0, 5'd23);
    chk("dn_valid", 32'(bus.resp_valid), 32'd1);
    chk("dn_ready", 32'(bus.req_ready), 32'd0);
    chk("dn_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk("dn_idle_mreq", 32'(bus.MREQ), 32'd0);
    chk("dn_idle_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("dn_next_mreq", 32'(bus.MREQ), 32'd1);
    chk("dn_next_dad", bus.DAD, 32'h0000_0030);
    bus.ACKD_n = 1'b0;
    bus.DDT_i  = 32'h0000_00C3;
    @(negedge clk);
    bus.ACKD_n = 1'b1;
    chk("dn_next_valid", 32'(bus.resp_valid), 32'd1);
    chk("dn_next_rdata", bus.resp_rdata, 32'hFFFF_FFC3);
    chk("dn_next_rd", 32'(bus.resp_rd), 32'd23);
    @(negedge clk);
    $display("txn done_hold: request deferred past DONE cycle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
